serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor, the inverse operation of the combinational full adder in the arithmetic lab set.
- Computes diff = a - b LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake, so it can sit behind a register-file or control FSM as a low-area ALU helper.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 131 +++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and default width for the serial arithmetic helpers
package arith_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit full subtractor cell computing a - b - bin
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with start/busy/done handshake
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   rs_q, rs_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               zero_q, zero_d;
    logic               fs_d, fs_b;
    logic               last;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_b)
    );

    assign last = cnt_q == CNT_W'(WIDTH - 1);
    assign busy = state_q == S_RUN;
    assign done = state_q == S_DONE;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

    // Next-state: capture operands on start, shift one bit per RUN cycle, publish on the last bit
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        rs_d     = rs_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                rs_d     = {fs_d, rs_q[WIDTH-1:1]};
                borrow_d = fs_b;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    diff_d  = rs_d;
                    bout_d  = fs_b;
                    zero_d  = rs_d == '0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation and clears the published result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            rs_q     <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            rs_q     <= rs_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor at WIDTH 8 and 4
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       s8_start, s4_start;
    logic [7:0] s8_a, s8_b, s8_diff;
    logic [3:0] s4_a, s4_b, s4_diff;
    logic       s8_busy, s8_done, s8_bout, s8_zero;
    logic       s4_busy, s4_done, s4_bout, s4_zero;
    int         vectors = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b),
        .busy(s8_busy), .done(s8_done), .diff(s8_diff), .bout(s8_bout), .zero(s8_zero)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b),
        .busy(s4_busy), .done(s4_done), .diff(s4_diff), .bout(s4_bout), .zero(s4_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; optional mid-run start pulse (ignore_at > 0) with junk operands
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int ignore_at);
        int n;
        logic [8:0] ref_d;
        ref_d = {1'b0, a} - {1'b0, b};
        @(negedge clk);
        s8_start = 1'b1; s8_a = a; s8_b = b;
        @(negedge clk);
        s8_start = 1'b0; s8_a = ~a; s8_b = ~b;
        n = 0;
        while (!s8_done && n < 20) begin
            check("busy8", 32'(s8_busy), 32'd1);
            s8_start = (n == ignore_at - 1);
            n++;
            @(negedge clk);
            s8_start = 1'b0;
        end
        check("lat8", n, 8);
        check("diff8", 32'(s8_diff), 32'(ref_d[7:0]));
        check("bout8", 32'(s8_bout), 32'(a < b));
        check("zero8", 32'(s8_zero), 32'(a == b));
        check("busy8_done", 32'(s8_busy), 32'd0);
        @(negedge clk);
        check("done8_pulse", 32'(s8_done), 32'd0);
    endtask

    initial begin
        int n, seen;
        logic [7:0] ra, rb;
        rst = 1'b1; s8_start = 1'b1; s4_start = 1'b1;
        s8_a = 8'h12; s8_b = 8'h01; s4_a = 4'h3; s4_b = 4'h1;
        repeat (2) @(negedge clk);
        rst = 1'b0; s8_start = 1'b0; s4_start = 1'b0;
        check("rst_busy", 32'(s8_busy), 32'd0);
        check("rst_done", 32'(s8_done), 32'd0);
        check("rst_diff", 32'(s8_diff), 32'd0);
        check("rst_bout", 32'(s8_bout), 32'd0);
        check("rst_zero", 32'(s8_zero), 32'd0);
        @(negedge clk);
        check("rst_start_ignored", 32'(s8_busy), 32'd0);

        run8(8'h05, 8'h03, 0);
        run8(8'h03, 8'h05, 0);
        run8(8'h00, 8'h01, 0);
        run8(8'h55, 8'h55, 0);
        run8(8'h80, 8'h01, 3);

        @(negedge clk);
        s8_start = 1'b1; s8_a = 8'hF0; s8_b = 8'h0F;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (s8_done) seen++;
            @(negedge clk);
        end
        check("abort_done", seen, 0);
        check("abort_busy", 32'(s8_busy), 32'd0);
        check("abort_diff", 32'(s8_diff), 32'd0);
        check("abort_bout", 32'(s8_bout), 32'd0);
        check("abort_zero", 32'(s8_zero), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
            run8(ra, rb, int'($urandom_range(0, 9)));
        end

        @(negedge clk);
        for (int p = 0; p < 256; p++) begin
            s4_start = 1'b1; s4_a = 4'(p >> 4); s4_b = 4'(p);
            @(negedge clk);
            s4_start = 1'b0;
            n = 0;
            seen = 0;
            while (!s4_done && n < 12) begin
                n++;
                @(negedge clk);
            end
            if (s4_done) seen++;
            check("lat4", n, 4);
            check("done4_once", seen, 1);
            check("diff4", 32'(s4_diff), 32'((p >> 4) - (p & 15)) & 32'hF);
            check("bout4", 32'(s4_bout), 32'((p >> 4) < (p & 15)));
            check("zero4", 32'(s4_zero), 32'((p >> 4) == (p & 15)));
            @(negedge clk);
            check("done4_pulse", 32'(s4_done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
